// File: rtl/data_mem_dp.sv
// data_mem_dp: dual-port data memory for the processor datapath.
//   Port A reads and writes with per-byte enables, port B is read-only.
//   A clear engine zeroes every word after reset (optional) or on request,
//   and Busy holds off the core while that sweep runs.
//   REG_OUT selects combinational reads or registered reads with
//   write-first forwarding from port A.

module data_mem_dp #(
  parameter int W              = 8,  // data width, multiple of 8
  parameter int A              = 8,  // address width, depth = 2**A
  parameter int REG_OUT        = 0,  // 0 = combinational reads, 1 = registered reads
  parameter int CLEAR_ON_RESET = 1   // 1 = sweep the array after every reset release
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Clear,
  input  logic           WriteEn,
  input  logic [W/8-1:0] ByteEn,
  input  logic [A-1:0]   AddrA,
  input  logic [W-1:0]   DataIn,
  input  logic [A-1:0]   AddrB,
  output logic [W-1:0]   DataOutA,
  output logic [W-1:0]   DataOutB,
  output logic           Busy
);

  localparam int NB    = W / 8;
  localparam int DEPTH = 1 << A;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t       r_state;
  logic [A-1:0] r_clr_addr;
  logic         r_busy;

  logic [W-1:0] r_core [DEPTH];

  logic         w_clr_we;
  logic         w_wr_we;
  logic [W-1:0] w_rd_a;
  logic [W-1:0] w_rd_b;

  // Clear-sweep controller: walks r_clr_addr over the whole array, Busy registered with the state.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_addr <= '0;
      r_busy     <= (CLEAR_ON_RESET != 0);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Clear) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == '1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = r_busy;

  // Nothing lands in the array while Reset is held: a write caught by reset is
  // dropped whole, and the sweep only starts once reset is released.
  // Clear in IDLE takes priority over a same-cycle write.
  assign w_clr_we = !Reset && (r_state == ST_CLEAR);
  assign w_wr_we  = !Reset && (r_state == ST_IDLE) && WriteEn && !Clear;

  // Storage array: sweep writes zero, otherwise port A merges enabled bytes.
  // NOTE: the array is deliberately left out of reset; clearing is the sweep's job.
  always_ff @(posedge Clk) begin
    if (w_clr_we) begin
      r_core[r_clr_addr] <= '0;
    end else if (w_wr_we) begin
      for (int i = 0; i < NB; i++) begin
        if (ByteEn[i]) begin
          r_core[AddrA][8*i +: 8] <= DataIn[8*i +: 8];
        end
      end
    end
  end

  assign w_rd_a = r_core[AddrA];
  assign w_rd_b = r_core[AddrB];

  if (REG_OUT != 0) begin : g_reg_out
    logic [W-1:0] w_merge;
    logic [W-1:0] r_out_a;
    logic [W-1:0] r_out_b;

    // Word as it will look after this edge's port A write (written bytes from DataIn).
    // NOTE: w_merge gets a full default first so no path leaves it unassigned (no latch).
    always_comb begin
      w_merge = w_rd_a;
      for (int i = 0; i < NB; i++) begin
        if (ByteEn[i]) begin
          w_merge[8*i +: 8] = DataIn[8*i +: 8];
        end
      end
    end

    // Output registers: zero while sweeping, write-first forwarding on an address hit.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_out_a <= '0;
        r_out_b <= '0;
      end else if (r_busy) begin
        r_out_a <= '0;
        r_out_b <= '0;
      end else begin
        r_out_a <= w_wr_we ? w_merge : w_rd_a;
        r_out_b <= (w_wr_we && (AddrB == AddrA)) ? w_merge : w_rd_b;
      end
    end

    assign DataOutA = r_out_a;
    assign DataOutB = r_out_b;
  end else begin : g_comb_out
    assign DataOutA = r_busy ? '0 : w_rd_a;
    assign DataOutB = r_busy ? '0 : w_rd_b;
  end

endmodule

// File: tb/tb_data_mem_dp.sv
// tb_data_mem_dp: directed test of data_mem_dp in three configurations.
//   u_comb : W=16, A=4, combinational reads, clear on reset
//   u_reg  : W=16, A=4, registered reads, clear on reset (shares u_comb's inputs)
//   u_nocl : W=8,  A=4, combinational reads, no clear on reset (own inputs)

module tb_data_mem_dp;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // shared stimulus for u_comb / u_reg
  logic        Reset, Clear, WriteEn;
  logic [1:0]  ByteEn;
  logic [3:0]  AddrA, AddrB;
  logic [15:0] DataIn;
  logic [15:0] outa0, outb0, outa1, outb1;
  logic        busy0, busy1;

  // stimulus for u_nocl
  logic        Reset2, Clear2, WriteEn2;
  logic [0:0]  ByteEn2;
  logic [3:0]  AddrA2, AddrB2;
  logic [7:0]  DataIn2;
  logic [7:0]  outa2, outb2;
  logic        busy2;

  int checks   = 0;
  int failures = 0;

  data_mem_dp #(.W(16), .A(4), .REG_OUT(0), .CLEAR_ON_RESET(1)) u_comb (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .WriteEn(WriteEn), .ByteEn(ByteEn),
    .AddrA(AddrA), .DataIn(DataIn), .AddrB(AddrB),
    .DataOutA(outa0), .DataOutB(outb0), .Busy(busy0)
  );

  data_mem_dp #(.W(16), .A(4), .REG_OUT(1), .CLEAR_ON_RESET(1)) u_reg (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .WriteEn(WriteEn), .ByteEn(ByteEn),
    .AddrA(AddrA), .DataIn(DataIn), .AddrB(AddrB),
    .DataOutA(outa1), .DataOutB(outb1), .Busy(busy1)
  );

  data_mem_dp #(.W(8), .A(4), .REG_OUT(0), .CLEAR_ON_RESET(0)) u_nocl (
    .Clk(Clk), .Reset(Reset2), .Clear(Clear2), .WriteEn(WriteEn2), .ByteEn(ByteEn2),
    .AddrA(AddrA2), .DataIn(DataIn2), .AddrB(AddrB2),
    .DataOutA(outa2), .DataOutB(outb2), .Busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    AddrA   = a;
    DataIn  = d;
    ByteEn  = be;
    WriteEn = 1'b1;
    tick();
    WriteEn = 1'b0;
    ByteEn  = 2'b00;
  endtask

  // one edge so the registered instance captures, comb instance is already valid
  task automatic rd(input logic [3:0] a);
    AddrA = a;
    AddrB = a;
    tick();
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d, input logic be);
    AddrA2     = a;
    DataIn2    = d;
    ByteEn2[0] = be;
    WriteEn2   = 1'b1;
    tick();
    WriteEn2   = 1'b0;
  endtask

  // counts remaining Busy cycles (bounded); nz counts any nonzero output or Busy disagreement
  task automatic count_busy(output int n, output int nz);
    n  = 0;
    nz = 0;
    while (busy0 && n < 100) begin
      if (outa0 != 16'h0 || outb0 != 16'h0) nz++;
      if (n >= 1 && (outa1 != 16'h0 || outb1 != 16'h0)) nz++;
      if (busy1 !== busy0) nz++;
      tick();
      n++;
    end
  endtask

  initial begin
    int n, nz;

    Reset = 1'b1; Clear = 1'b0; WriteEn = 1'b0; ByteEn = '0;
    AddrA = '0; AddrB = '0; DataIn = '0;
    Reset2 = 1'b1; Clear2 = 1'b0; WriteEn2 = 1'b0; ByteEn2 = '0;
    AddrA2 = '0; AddrB2 = '0; DataIn2 = '0;

    // reset state
    tick(); tick();
    check("rst_busy_comb", busy0, 1'b1);
    check("rst_busy_reg", busy1, 1'b1);
    check("rst_outa_comb", outa0, 16'h0);
    check("rst_outa_reg", outa1, 16'h0);
    check("rst_busy_nocl", busy2, 1'b0);
    Reset = 1'b0;
    count_busy(n, nz);
    check("first_sweep_len", n, 16);

    // preload every word with all ones, then reset to trigger the sweep
    for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF, 2'b11);
    rd(4'd5);
    check("preload_comb", outa0, 16'hFFFF);
    check("preload_reg", outb1, 16'hFFFF);
    Reset = 1'b1;
    tick();
    check("reset_hold_busy", busy0, 1'b1);
    check("reset_hold_out0", outa0, 16'h0);
    Reset = 1'b0;
    count_busy(n, nz);
    check("sweep_len_after_reset", n, 16);
    check("zero_out_during_busy", nz, 0);
    check("idle_after_sweep", busy0, 1'b0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check($sformatf("cleared_comb_%0d", a), outa0, 16'h0);
      check($sformatf("cleared_reg_%0d", a), outb1, 16'h0);
    end

    // byte enables
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3);
    check("be01_comb", outa0, 16'hAB34);
    check("be01_reg", outa1, 16'hAB34);
    wr(4'd3, 16'h1234, 2'b00);
    rd(4'd3);
    check("be00_comb", outa0, 16'hAB34);
    check("be00_reg_b", outb1, 16'hAB34);

    // write-first forwarding: addr 7 is zero, write 0x5A while B also reads 7
    AddrA = 4'd7; AddrB = 4'd7; DataIn = 16'h005A; ByteEn = 2'b11; WriteEn = 1'b1;
    #1;
    check("comb_before_edge", outa0, 16'h0);
    tick();
    WriteEn = 1'b0; ByteEn = 2'b00;
    check("fwd_reg_a", outa1, 16'h005A);
    check("fwd_reg_b", outb1, 16'h005A);
    check("comb_after_edge", outb0, 16'h005A);
    // partial forward merges old low byte with new high byte; B on another address
    AddrA = 4'd7; AddrB = 4'd3; DataIn = 16'hC3FF; ByteEn = 2'b10; WriteEn = 1'b1;
    tick();
    WriteEn = 1'b0; ByteEn = 2'b00;
    check("fwd_merge_a", outa1, 16'hC35A);
    check("nofwd_b", outb1, 16'hAB34);
    check("same_addr_ports", outb0, outa0 == 16'hC35A ? 16'hAB34 : 16'hFFFF);

    // Clear beats a same-cycle write; writes during Busy are ignored
    wr(4'd2, 16'h1111, 2'b11);
    wr(4'd0, 16'h2222, 2'b11);
    AddrA = 4'd2; DataIn = 16'h0077; ByteEn = 2'b11; WriteEn = 1'b1; Clear = 1'b1;
    tick();
    check("clear_starts_busy", busy0, 1'b1);
    AddrA = 4'd0; DataIn = 16'h0099;
    tick(); tick();
    WriteEn = 1'b0; Clear = 1'b0; ByteEn = 2'b00;
    count_busy(n, nz);
    check("clear_sweep_len", n + 2, 16);
    check("clear_zero_out", nz, 0);
    rd(4'd2);
    check("clear_dropped_write", outa0, 16'h0);
    check("clear_dropped_write_reg", outa1, 16'h0);
    rd(4'd0);
    check("busy_write_ignored", outa0, 16'h0);

    // reset in the middle of a sweep restarts it from address 0
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (9) tick();
    check("mid_sweep_busy", busy0, 1'b1);
    Reset = 1'b1;
    #1;
    check("mid_sweep_reset_busy", busy0, 1'b1);
    tick();
    Reset = 1'b0;
    count_busy(n, nz);
    check("restart_sweep_len", n, 16);

    // no clear on reset: contents survive, write caught by reset is dropped
    Reset2 = 1'b0;
    #1;
    check("nocl_busy_release", busy2, 1'b0);
    wr2(4'd5, 8'h42, 1'b1);
    wr2(4'd4, 8'h11, 1'b1);
    wr2(4'd4, 8'hFF, 1'b0);
    AddrA2 = 4'd4; AddrB2 = 4'd4;
    #1;
    check("nocl_be0_noop", outa2, 8'h11);
    check("nocl_same_addr", outb2, 8'h11);
    AddrA2 = 4'd4; DataIn2 = 8'hEE; ByteEn2 = 1'b1; WriteEn2 = 1'b1; Reset2 = 1'b1;
    tick(); tick();
    Reset2 = 1'b0; WriteEn2 = 1'b0;
    #1;
    check("nocl_busy_after_reset", busy2, 1'b0);
    check("nocl_reset_write_lost", outa2, 8'h11);
    AddrA2 = 4'd5; AddrB2 = 4'd5;
    #1;
    check("nocl_preserved_a", outa2, 8'h42);
    check("nocl_preserved_b", outb2, 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
